// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID skid stage.
// Occupancy states and the architectural NOP word.
package if_id_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam logic [31:0] NOP_DEFAULT = 32'hD503201F;

  localparam int unsigned INSTR_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT  = 64;
  localparam int unsigned CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/register.sv
// Plain enable register used for pipeline entry storage.
// Contents carry no reset value; the owner tracks validity.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage with a 2-entry skid buffer, flush and kill counter.
// in_ready comes from the state register, so no decode->fetch path.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               flush,
  output logic [CNT_W-1:0]   kill_cnt
);

  localparam int unsigned E_W = INSTR_W + ADDR_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  skid_state_t state_q;
  skid_state_t state_d;

  entry_t in_entry;
  entry_t main_q;
  entry_t main_d;
  entry_t skid_q;

  logic main_en;
  logic skid_en;
  logic main_from_skid;

  logic in_fire;
  logic out_fire;

  logic [1:0]     drop;
  logic [CNT_W:0] kill_sum;
  logic [CNT_W-1:0] kill_q;
  logic [CNT_W-1:0] kill_d;

  assign in_entry.instr = in_instr;
  assign in_entry.pc    = in_pc;

  assign in_ready  = (state_q != TWO) & ~rst;
  assign out_valid = (state_q != EMPTY);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_en = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire & out_fire) begin
          main_en = 1'b1;
        end else if (in_fire) begin
          skid_en = 1'b1;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Entry loads during a flush are harmless: state goes EMPTY.
    if (flush) state_d = EMPTY;
  end

  assign main_d = main_from_skid ? skid_q : in_entry;

  register #(.WIDTH(E_W)) u_main (
    .clk (clk),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  register #(.WIDTH(E_W)) u_skid (
    .clk (clk),
    .en  (skid_en),
    .d   (in_entry),
    .q   (skid_q)
  );

  // Held entries not delivered this cycle, plus the incoming beat.
  always_comb begin
    drop = 2'd0;
    unique case (state_q)
      ONE:     drop = out_fire ? 2'd0 : 2'd1;
      TWO:     drop = out_fire ? 2'd1 : 2'd2;
      default: drop = 2'd0;
    endcase
    if (in_fire) drop = drop + 2'd1;
  end

  assign kill_sum = {1'b0, kill_q} + {{(CNT_W-1){1'b0}}, drop};

  always_comb begin
    kill_d = kill_q;
    if (flush) begin
      kill_d = kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      kill_q  <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  assign out_instr = out_valid ? main_q.instr : NOP_INSTR;
  assign out_pc    = out_valid ? main_q.pc : '0;
  assign kill_cnt  = kill_q;

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage for the pipelined CPU: carries instruction word and PC from fetch to decode with a valid/ready handshake, a 2-entry skid buffer (fully registered upstream ready), synchronous flush for branch redirects, and a saturating count of killed instructions. It replaces the plain enable-register IF/ID pair. It supports back-to-back throughput under decode stalls without a combinational ready path from decode to fetch.

## Interface
Parameters:
- INSTR_W, 32, instruction word width
- ADDR_W, 64, PC width
- NOP_INSTR, 32'hD503201F, word driven on out_instr while out_valid=0 (width INSTR_W)
- CNT_W, 16, width of kill counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch offers a beat
- in_ready  out  1  stage accepts a beat; depends on state register only
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  ADDR_W  PC of fetched instruction
- out_valid  out  1  decode-side beat valid
- out_ready  in  1  decode accepts beat
- out_instr  out  INSTR_W  instruction to decode
- out_pc  out  ADDR_W  PC to decode
- flush  in  1  discard all held and incoming beats this cycle
- kill_cnt  out  CNT_W  saturating count of discarded valid beats

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry, each {instr, pc}.
- States: EMPTY (no entries), ONE (main valid), TWO (main+skid valid).
- in_ready = (state != TWO) & ~rst. out_valid = (state != EMPTY).
- out_instr/out_pc = main entry when out_valid, else NOP_INSTR / 0.
- Transitions (flush=0):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE: in_fire & out_fire -> ONE, main<=in; in_fire & ~out_fire -> TWO, skid<=in; ~in_fire & out_fire -> EMPTY; else hold.
  - TWO: out_fire -> ONE, main<=skid; else hold (in_fire impossible).
- Flush: next state EMPTY regardless of other inputs. A beat completing out_fire in the flush cycle counts as delivered. Discarded = held entries not delivered + in_fire beat (0..2). kill_cnt += discarded, saturating at all-ones.
- Order preserved: beats leave in acceptance order; no duplication, no loss absent flush.

## Timing
- Reset (rst high at edge): state EMPTY, out_valid=0, in_ready=0 while rst high, out_instr=NOP_INSTR, out_pc=0, kill_cnt=0; entry data contents don't-care. in_ready=1 first cycle after rst deasserts.
- Reset mid-operation: held beats dropped, not counted in kill_cnt.
- Latency: in_fire at edge N -> out_valid with that beat after edge N (visible cycle N+1) when stage was EMPTY or ONE with out_fire.
- Throughput 1 beat/cycle with out_ready held high.
- in_ready falls the cycle after entering TWO; one beat absorbed after decode stall begins.
- flush and rst both high: rst wins, kill_cnt cleared.
- Outputs registered or decoded from state only; no combinational in->out path.

## Structure
- Package if_id_pkg: state enum {EMPTY, ONE, TWO} (2-bit), default NOP constant, entry struct typedef parametrised via localparam widths in the module.
- Sub-module: team's existing enable register, register #(WIDTH), instantiated for main and skid entries (width INSTR_W+ADDR_W); FSM, mux, and counter in the top.

## Test plan
- Reset then stream: rst 2 cycles, in_valid=1 with PC 0x0,0x4,0x8, out_ready=1 -> out_pc 0x0,0x4,0x8 on consecutive cycles starting 1 cycle later; in_ready stays 1.
- Stall absorb: stream PC 0x100.., out_ready=0 at cycle 3 -> one extra beat taken, in_ready=0 next cycle; release -> 0x100..0x10C delivered in order, none lost.
- Flush in TWO with in_valid=1, out_ready=0 -> next cycle out_valid=0, out_instr=0xD503201F, kill_cnt=2.
- Flush in ONE with out_ready=1 and in_fire -> main counted delivered, incoming killed, kill_cnt +1, state EMPTY.
- Saturation: CNT_W=2, repeated flushes killing 2 beats -> kill_cnt 2,3,3.
- rst mid-stream in TWO with flush=1 -> all outputs at reset values, kill_cnt=0.
